lsq_ret_bundle_buf: RTL and testbench
=====================================

// Module: lsq_ret_bundle_buf
// PURPOSE
//  Per-thread FIFO of LSQ retire bundles; feeds head bundle to lsq_decide_ret via dataB_* ports.
//  Allocated in program order at dispatch (6 mem slots, bundle II); slots filled by 2 LSU completion ports.
//  Head is presented as ready once every masked slot has completed; popped on dataB_enOut; flushed on except.
// PARAMETERS
//  DEPTH      16   bundle entries (power of 2); PTR_W=log2(DEPTH)
//  THREAD_ID  0    thread served; driven on dataB_thread, matched against except_thread
//  SHR_W      `lsqshare_width  width of per-bundle shared data
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous active-high reset
//  alloc_en         in   1      allocate bundle (accepted only when alloc_rdy)
//  alloc_II         in   6      bundle retire index
//  alloc_mask       in   6      slots in use
//  alloc_slotII     in   24     4-bit retire sub-index per slot, slot s at [4s+:4]
//  alloc_shr        in   SHR_W  shared bundle data
//  alloc_rdy        out  1      count<DEPTH
//  alloc_ptr        out  PTR_W  entry index given to the allocating bundle (= tail)
//  cmplA_en/cmplB_en        in 1      completion valid, ports A/B
//  cmplA_ptr/cmplB_ptr      in PTR_W  target entry
//  cmplA_slot/cmplB_slot    in 3      target slot 0..5
//  cmplA_excpt/cmplB_excpt  in 1      exception flag
//  cmplA_exbits/cmplB_exbits in 4     exception code
//  cmplA_ldconfl/cmplB_ldconfl in 1   load conflict
//  cmplA_waitconfl/cmplB_waitconfl in 1 wait conflict
//  dataB_ready      out  1      head valid and all masked slots done
//  dataB_ret_mask   out  6      head mask
//  dataB_excpt/dataB_ld_confl/dataB_wait_confl out 6 per-slot flags
//  dataB_exbits     out  24     per-slot codes
//  dataB_II         out  6      head bundle II
//  dataB_II0..dataB_II5 out 4   head slot sub-indices
//  dataB_data_shr   out  SHR_W  head shared data
//  dataB_thread     out  1      constant THREAD_ID
//  dataB_enOut      in   1      pop head (already qualified with bStall by consumer)
//  except           in   1      flush request
//  except_thread    in   1      flush thread
//  count            out  PTR_W+1 occupied entries
// BEHAVIOUR
//  - Reset: head=tail=count=0, all valid/done bits 0; alloc_rdy=1, dataB_ready=0, all dataB_* data outputs 0.
//  - Storage registered; dataB_* combinational from head entry; when head invalid all dataB_* data outputs =0.
//  - Alloc: alloc_en&alloc_rdy writes tail entry, valid=1, done[5:0]=~alloc_mask, flags/exbits cleared; tail++ (wraps mod DEPTH).
//  - alloc_rdy uses registered count; a same-cycle pop does NOT free a slot for a full-buffer alloc.
//  - alloc_mask=0: entry is ready immediately next cycle (all done).
//  - Completion: sets done[slot], writes excpt/exbits/ldconfl/waitconfl; visible on dataB_* the next cycle (1-cycle latency).
//  - Completion ignored if entry invalid, slot>5, or slot not in mask. A and B same ptr+slot same cycle: B wins.
//  - Completion to a slot already done overwrites its flags (latest wins).
//  - Pop: dataB_enOut&dataB_ready clears head valid, head++; dataB_enOut while ~dataB_ready ignored.
//  - Completion targeting head in the pop cycle is dropped with the entry.
//  - Alloc+pop same cycle: count unchanged; alloc+pop when count==1 and new entry ready-at-alloc: new entry is head next cycle.
//  - Flush: except&(except_thread==THREAD_ID) clears all valid, head=tail=count=0; overrides alloc, pop, completions that cycle.
//  - except for other thread: no effect.
// TESTING
//  1 Reset, alloc II=5 mask=6'b000011, cmplA slot0, cmplB slot1 same cycle -> dataB_ready=1 next cycle, dataB_II=5.
//  2 Fill 16 entries -> alloc_rdy=0, count=16; alloc+pop same cycle -> alloc dropped, count=15; wrap: 20 alloc/pop pairs keep FIFO order of II.
//  3 cmplA slot2 excpt=1 exbits=4'hA, ldconfl on slot3 -> dataB_excpt=6'b000100, dataB_exbits[11:8]=4'hA, dataB_ld_confl=6'b001000.
//  4 Completions to unmasked slot 4 and invalid ptr -> no state change; A/B same slot, A exbits=1 B exbits=2 -> exbits=2.
//  5 8 entries queued, except with except_thread=THREAD_ID plus alloc same cycle -> count=0, dataB_ready=0, alloc_ptr=0 next cycle; other thread -> count stays 8.
//  6 rst asserted mid-fill with pending completions -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/lsq_ret_bundle_buf.sv
// Per-thread FIFO of LSQ retire bundles: allocated in program order at dispatch,
// slots completed by two LSU ports, head presented to the retire decision logic.
`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 16
`endif

module lsq_ret_bundle_buf #(
    parameter int unsigned DEPTH     = 16,
    parameter bit          THREAD_ID = 1'b0,
    parameter int unsigned SHR_W     = `LSQSHARE_WIDTH,
    localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [5:0]       alloc_II,
    input  logic [5:0]       alloc_mask,
    input  logic [23:0]      alloc_slotII,
    input  logic [SHR_W-1:0] alloc_shr,
    output logic             alloc_rdy,
    output logic [PTR_W-1:0] alloc_ptr,
    input  logic             cmplA_en,
    input  logic [PTR_W-1:0] cmplA_ptr,
    input  logic [2:0]       cmplA_slot,
    input  logic             cmplA_excpt,
    input  logic [3:0]       cmplA_exbits,
    input  logic             cmplA_ldconfl,
    input  logic             cmplA_waitconfl,
    input  logic             cmplB_en,
    input  logic [PTR_W-1:0] cmplB_ptr,
    input  logic [2:0]       cmplB_slot,
    input  logic             cmplB_excpt,
    input  logic [3:0]       cmplB_exbits,
    input  logic             cmplB_ldconfl,
    input  logic             cmplB_waitconfl,
    output logic             dataB_ready,
    output logic [5:0]       dataB_ret_mask,
    output logic [5:0]       dataB_excpt,
    output logic [5:0]       dataB_ld_confl,
    output logic [5:0]       dataB_wait_confl,
    output logic [23:0]      dataB_exbits,
    output logic [5:0]       dataB_II,
    output logic [3:0]       dataB_II0,
    output logic [3:0]       dataB_II1,
    output logic [3:0]       dataB_II2,
    output logic [3:0]       dataB_II3,
    output logic [3:0]       dataB_II4,
    output logic [3:0]       dataB_II5,
    output logic [SHR_W-1:0] dataB_data_shr,
    output logic             dataB_thread,
    input  logic             dataB_enOut,
    input  logic             except,
    input  logic             except_thread,
    output logic [PTR_W:0]   count
);

    localparam int unsigned SLOTS = 6;

    logic [DEPTH-1:0] valid_q;
    logic [5:0]       done_q   [DEPTH];
    logic [5:0]       mask_q   [DEPTH];
    logic [5:0]       excpt_q  [DEPTH];
    logic [5:0]       ldc_q    [DEPTH];
    logic [5:0]       wc_q     [DEPTH];
    logic [23:0]      exbits_q [DEPTH];
    logic [5:0]       ii_q     [DEPTH];
    logic [23:0]      slot_ii_q[DEPTH];
    logic [SHR_W-1:0] shr_q    [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;

    logic       head_valid;
    logic       alloc_fire;
    logic       pop_fire;
    logic       flush;
    logic [5:0] hit_a;
    logic [5:0] hit_b;
    logic [23:0] head_slot_ii;

    assign head_valid = valid_q[head_q];
    assign dataB_ready = head_valid & (&done_q[head_q]);
    assign alloc_rdy  = count_q < (PTR_W+1)'(DEPTH);
    assign alloc_fire = alloc_en & alloc_rdy;
    assign pop_fire   = dataB_enOut & dataB_ready;
    assign flush      = except & (except_thread == THREAD_ID);

    // Completion only lands on a live, masked slot 0..5; the head being popped drops it.
    assign hit_a = {SLOTS{cmplA_en & valid_q[cmplA_ptr] & ~(pop_fire & (cmplA_ptr == head_q))}}
                 & mask_q[cmplA_ptr] & (6'b000001 << cmplA_slot);
    assign hit_b = {SLOTS{cmplB_en & valid_q[cmplB_ptr] & ~(pop_fire & (cmplB_ptr == head_q))}}
                 & mask_q[cmplB_ptr] & (6'b000001 << cmplB_slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                done_q[i]    <= '0;
                mask_q[i]    <= '0;
                excpt_q[i]   <= '0;
                ldc_q[i]     <= '0;
                wc_q[i]      <= '0;
                exbits_q[i]  <= '0;
                ii_q[i]      <= '0;
                slot_ii_q[i] <= '0;
                shr_q[i]     <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Port B is applied after port A so it wins on a shared ptr+slot.
            for (int s = 0; s < int'(SLOTS); s++) begin
                if (hit_a[s]) begin
                    done_q[cmplA_ptr][s]        <= 1'b1;
                    excpt_q[cmplA_ptr][s]       <= cmplA_excpt;
                    ldc_q[cmplA_ptr][s]         <= cmplA_ldconfl;
                    wc_q[cmplA_ptr][s]          <= cmplA_waitconfl;
                    exbits_q[cmplA_ptr][4*s+:4] <= cmplA_exbits;
                end
            end
            for (int s = 0; s < int'(SLOTS); s++) begin
                if (hit_b[s]) begin
                    done_q[cmplB_ptr][s]        <= 1'b1;
                    excpt_q[cmplB_ptr][s]       <= cmplB_excpt;
                    ldc_q[cmplB_ptr][s]         <= cmplB_ldconfl;
                    wc_q[cmplB_ptr][s]          <= cmplB_waitconfl;
                    exbits_q[cmplB_ptr][4*s+:4] <= cmplB_exbits;
                end
            end
            if (alloc_fire) begin
                valid_q[tail_q]   <= 1'b1;
                done_q[tail_q]    <= ~alloc_mask;
                mask_q[tail_q]    <= alloc_mask;
                excpt_q[tail_q]   <= '0;
                ldc_q[tail_q]     <= '0;
                wc_q[tail_q]      <= '0;
                exbits_q[tail_q]  <= '0;
                ii_q[tail_q]      <= alloc_II;
                slot_ii_q[tail_q] <= alloc_slotII;
                shr_q[tail_q]     <= alloc_shr;
                tail_q            <= tail_q + PTR_W'(1);
            end
            if (pop_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(pop_fire);
        end
    end

    // Head view; everything reads zero while the head entry is empty.
    assign dataB_ret_mask   = head_valid ? mask_q[head_q]   : '0;
    assign dataB_excpt      = head_valid ? excpt_q[head_q]  : '0;
    assign dataB_ld_confl   = head_valid ? ldc_q[head_q]    : '0;
    assign dataB_wait_confl = head_valid ? wc_q[head_q]     : '0;
    assign dataB_exbits     = head_valid ? exbits_q[head_q] : '0;
    assign dataB_II         = head_valid ? ii_q[head_q]     : '0;
    assign dataB_data_shr   = head_valid ? shr_q[head_q]    : '0;
    assign head_slot_ii     = head_valid ? slot_ii_q[head_q] : '0;
    assign dataB_II0        = head_slot_ii[3:0];
    assign dataB_II1        = head_slot_ii[7:4];
    assign dataB_II2        = head_slot_ii[11:8];
    assign dataB_II3        = head_slot_ii[15:12];
    assign dataB_II4        = head_slot_ii[19:16];
    assign dataB_II5        = head_slot_ii[23:20];
    assign dataB_thread     = THREAD_ID;

    assign alloc_ptr = tail_q;
    assign count     = count_q;

endmodule

// File: tb/tb_lsq_ret_bundle_buf.sv
// Bench for lsq_ret_bundle_buf: directed stimulus, head bundles checked by a
// scoreboard monitor at every pop, plus direct status checks.
module tb_lsq_ret_bundle_buf;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = 4;
    localparam int unsigned SHR_W = 16;
    localparam logic [23:0] SLOT_II = 24'h543210;

    typedef struct {
        logic [5:0]  ii;
        logic [5:0]  mask;
        logic [5:0]  excpt;
        logic [5:0]  ldc;
        logic [5:0]  wc;
        logic [23:0] exbits;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic alloc_en;
    logic [5:0] alloc_II, alloc_mask;
    logic [23:0] alloc_slotII;
    logic [SHR_W-1:0] alloc_shr;
    logic alloc_rdy;
    logic [PTR_W-1:0] alloc_ptr;
    logic cmplA_en, cmplB_en;
    logic [PTR_W-1:0] cmplA_ptr, cmplB_ptr;
    logic [2:0] cmplA_slot, cmplB_slot;
    logic cmplA_excpt, cmplB_excpt;
    logic [3:0] cmplA_exbits, cmplB_exbits;
    logic cmplA_ldconfl, cmplB_ldconfl, cmplA_waitconfl, cmplB_waitconfl;
    logic dataB_ready;
    logic [5:0] dataB_ret_mask, dataB_excpt, dataB_ld_confl, dataB_wait_confl, dataB_II;
    logic [23:0] dataB_exbits;
    logic [3:0] dataB_II0, dataB_II1, dataB_II2, dataB_II3, dataB_II4, dataB_II5;
    logic [SHR_W-1:0] dataB_data_shr;
    logic dataB_thread;
    logic dataB_enOut;
    logic except, except_thread;
    logic [PTR_W:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t exp_q[$];
    logic [5:0] model_q[$];
    logic [PTR_W-1:0] tail_m;

    lsq_ret_bundle_buf #(.DEPTH(DEPTH), .THREAD_ID(1'b0), .SHR_W(SHR_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_en(alloc_en), .alloc_II(alloc_II), .alloc_mask(alloc_mask),
        .alloc_slotII(alloc_slotII), .alloc_shr(alloc_shr),
        .alloc_rdy(alloc_rdy), .alloc_ptr(alloc_ptr),
        .cmplA_en(cmplA_en), .cmplA_ptr(cmplA_ptr), .cmplA_slot(cmplA_slot),
        .cmplA_excpt(cmplA_excpt), .cmplA_exbits(cmplA_exbits),
        .cmplA_ldconfl(cmplA_ldconfl), .cmplA_waitconfl(cmplA_waitconfl),
        .cmplB_en(cmplB_en), .cmplB_ptr(cmplB_ptr), .cmplB_slot(cmplB_slot),
        .cmplB_excpt(cmplB_excpt), .cmplB_exbits(cmplB_exbits),
        .cmplB_ldconfl(cmplB_ldconfl), .cmplB_waitconfl(cmplB_waitconfl),
        .dataB_ready(dataB_ready), .dataB_ret_mask(dataB_ret_mask),
        .dataB_excpt(dataB_excpt), .dataB_ld_confl(dataB_ld_confl),
        .dataB_wait_confl(dataB_wait_confl), .dataB_exbits(dataB_exbits),
        .dataB_II(dataB_II), .dataB_II0(dataB_II0), .dataB_II1(dataB_II1),
        .dataB_II2(dataB_II2), .dataB_II3(dataB_II3), .dataB_II4(dataB_II4),
        .dataB_II5(dataB_II5), .dataB_data_shr(dataB_data_shr),
        .dataB_thread(dataB_thread), .dataB_enOut(dataB_enOut),
        .except(except), .except_thread(except_thread), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted pop is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && dataB_enOut && dataB_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_pop: got II 0x%0h expected no pop", dataB_II);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_II", 32'(dataB_II), 32'(e.ii));
                chk("sb_mask", 32'(dataB_ret_mask), 32'(e.mask));
                chk("sb_excpt", 32'(dataB_excpt), 32'(e.excpt));
                chk("sb_ldconfl", 32'(dataB_ld_confl), 32'(e.ldc));
                chk("sb_waitconfl", 32'(dataB_wait_confl), 32'(e.wc));
                chk("sb_exbits", 32'(dataB_exbits), 32'(e.exbits));
                chk("sb_slotII", 32'({dataB_II5, dataB_II4, dataB_II3, dataB_II2, dataB_II1, dataB_II0}),
                    32'(SLOT_II));
                chk("sb_shr", 32'(dataB_data_shr), 32'(16'(e.ii) ^ 16'hA5A5));
                chk("sb_thread", 32'(dataB_thread), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic clear_strobes();
        alloc_en = 1'b0; cmplA_en = 1'b0; cmplB_en = 1'b0;
        dataB_enOut = 1'b0; except = 1'b0;
        cmplA_excpt = 1'b0; cmplA_exbits = 4'h0; cmplA_ldconfl = 1'b0; cmplA_waitconfl = 1'b0;
        cmplB_excpt = 1'b0; cmplB_exbits = 4'h0; cmplB_ldconfl = 1'b0; cmplB_waitconfl = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic set_alloc(input logic [5:0] ii, input logic [5:0] mask);
        alloc_en = 1'b1;
        alloc_II = ii;
        alloc_mask = mask;
        alloc_slotII = SLOT_II;
        alloc_shr = 16'(ii) ^ 16'hA5A5;
    endtask

    task automatic set_pop(input logic [5:0] ii, input logic [5:0] mask, input logic [5:0] excpt,
                           input logic [5:0] ldc, input logic [5:0] wc, input logic [23:0] exbits);
        exp_t e;
        e.ii = ii; e.mask = mask; e.excpt = excpt; e.ldc = ldc; e.wc = wc; e.exbits = exbits;
        exp_q.push_back(e);
        dataB_enOut = 1'b1;
    endtask

    task automatic set_cmpl(input bit port_b, input logic [PTR_W-1:0] ptr, input logic [2:0] slot,
                            input logic ex, input logic [3:0] exb, input logic ldc, input logic wc);
        if (port_b) begin
            cmplB_en = 1'b1; cmplB_ptr = ptr; cmplB_slot = slot;
            cmplB_excpt = ex; cmplB_exbits = exb; cmplB_ldconfl = ldc; cmplB_waitconfl = wc;
        end else begin
            cmplA_en = 1'b1; cmplA_ptr = ptr; cmplA_slot = slot;
            cmplA_excpt = ex; cmplA_exbits = exb; cmplA_ldconfl = ldc; cmplA_waitconfl = wc;
        end
    endtask

    initial begin
        clear_strobes();
        rst = 1'b1; except_thread = 1'b0;
        alloc_II = '0; alloc_mask = '0; alloc_slotII = '0; alloc_shr = '0;
        cmplA_ptr = '0; cmplA_slot = '0; cmplB_ptr = '0; cmplB_slot = '0;
        tail_m = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alloc_rdy", 32'(alloc_rdy), 32'd1);
        chk("rst_ready", 32'(dataB_ready), 32'd0);
        chk("rst_II", 32'(dataB_II), 32'd0);
        chk("rst_alloc_ptr", 32'(alloc_ptr), 32'd0);

        // Two slots completed by both ports in one cycle.
        set_alloc(6'd5, 6'b000011); tick(); tail_m++;
        chk("t1_not_ready", 32'(dataB_ready), 32'd0);
        set_cmpl(1'b0, 4'd0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0);
        set_cmpl(1'b1, 4'd0, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        chk("t1_ready", 32'(dataB_ready), 32'd1);
        chk("t1_II", 32'(dataB_II), 32'd5);
        set_pop(6'd5, 6'b000011, '0, '0, '0, '0); tick();
        chk("t1_count_after_pop", 32'(count), 32'd0);

        // Fill to full, dropped alloc on full, then wrap with paired alloc/pop.
        for (int i = 0; i < 16; i++) begin
            set_alloc(6'(i), 6'b000000); tick();
            model_q.push_back(6'(i)); tail_m++;
        end
        chk("t2_full_rdy", 32'(alloc_rdy), 32'd0);
        chk("t2_full_count", 32'(count), 32'd16);
        chk("t2_full_ptr", 32'(alloc_ptr), 32'(tail_m));
        set_alloc(6'd40, 6'b000000);
        set_pop(model_q.pop_front(), '0, '0, '0, '0, '0);
        tick();
        chk("t2_drop_count", 32'(count), 32'd15);
        for (int k = 0; k < 20; k++) begin
            set_alloc(6'(20 + k), 6'b000000);
            set_pop(model_q.pop_front(), '0, '0, '0, '0, '0);
            model_q.push_back(6'(20 + k)); tail_m++;
            tick();
        end
        chk("t2_pair_count", 32'(count), 32'd15);
        while (model_q.size() != 0) begin
            set_pop(model_q.pop_front(), '0, '0, '0, '0, '0);
            tick();
        end
        chk("t2_drained", 32'(count), 32'd0);
        chk("t2_tail", 32'(alloc_ptr), 32'(tail_m));

        // Exception and load-conflict flags routed to their slots.
        set_alloc(6'd7, 6'b001100); tick();
        set_cmpl(1'b0, tail_m, 3'd2, 1'b1, 4'hA, 1'b0, 1'b0);
        set_cmpl(1'b1, tail_m, 3'd3, 1'b0, 4'h0, 1'b1, 1'b0);
        tail_m++;
        tick();
        chk("t3_ready", 32'(dataB_ready), 32'd1);
        chk("t3_excpt", 32'(dataB_excpt), 32'h04);
        chk("t3_exbits_s2", 32'(dataB_exbits[11:8]), 32'hA);
        chk("t3_ldconfl", 32'(dataB_ld_confl), 32'h08);
        set_pop(6'd7, 6'b001100, 6'b000100, 6'b001000, '0, 24'h000A00); tick();

        // Ignored completions, ignored pop, then B beats A on the same slot.
        set_alloc(6'd9, 6'b000011); tick();
        set_cmpl(1'b0, tail_m, 3'd4, 1'b1, 4'hF, 1'b1, 1'b1);
        set_cmpl(1'b1, tail_m, 3'd6, 1'b1, 4'hF, 1'b1, 1'b1);
        tick();
        set_cmpl(1'b0, tail_m + 4'd1, 3'd0, 1'b1, 4'hF, 1'b1, 1'b1);
        dataB_enOut = 1'b1;
        tick();
        chk("t4_not_ready", 32'(dataB_ready), 32'd0);
        chk("t4_excpt_clean", 32'(dataB_excpt), 32'd0);
        chk("t4_exbits_clean", 32'(dataB_exbits), 32'd0);
        chk("t4_count", 32'(count), 32'd1);
        set_cmpl(1'b0, tail_m, 3'd0, 1'b1, 4'h1, 1'b0, 1'b0);
        set_cmpl(1'b1, tail_m, 3'd0, 1'b1, 4'h2, 1'b0, 1'b0);
        tick();
        set_cmpl(1'b0, tail_m, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0);
        tail_m++;
        tick();
        chk("t4_ready", 32'(dataB_ready), 32'd1);
        chk("t4_exbits_b_wins", 32'(dataB_exbits[3:0]), 32'd2);
        set_pop(6'd9, 6'b000011, 6'b000001, '0, '0, 24'h000002); tick();

        // Flush: other thread ignored, own thread wins over a same-cycle alloc.
        for (int i = 0; i < 8; i++) begin
            set_alloc(6'(50 + i), 6'b000000); tick();
        end
        chk("t5_count8", 32'(count), 32'd8);
        except = 1'b1; except_thread = 1'b1; tick();
        chk("t5_other_thread", 32'(count), 32'd8);
        except = 1'b1; except_thread = 1'b0; set_alloc(6'd60, 6'b000000); tick();
        chk("t5_flush_count", 32'(count), 32'd0);
        chk("t5_flush_ready", 32'(dataB_ready), 32'd0);
        chk("t5_flush_ptr", 32'(alloc_ptr), 32'd0);
        chk("t5_flush_II", 32'(dataB_II), 32'd0);

        // Reset mid-fill with completions in flight.
        for (int i = 0; i < 3; i++) begin
            set_alloc(6'(i + 1), 6'b000011); tick();
        end
        set_cmpl(1'b0, 4'd0, 3'd0, 1'b1, 4'h3, 1'b0, 1'b0);
        set_cmpl(1'b1, 4'd0, 3'd1, 1'b0, 4'h0, 1'b1, 1'b0);
        set_alloc(6'd4, 6'b000011);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_alloc_rdy", 32'(alloc_rdy), 32'd1);
        chk("t6_ready", 32'(dataB_ready), 32'd0);
        chk("t6_mask", 32'(dataB_ret_mask), 32'd0);
        chk("t6_exbits", 32'(dataB_exbits), 32'd0);
        chk("t6_alloc_ptr", 32'(alloc_ptr), 32'd0);
        set_alloc(6'd3, 6'b000000); tick();
        chk("t6_realloc_ready", 32'(dataB_ready), 32'd1);
        set_pop(6'd3, '0, '0, '0, '0, '0); tick();
        chk("t6_final_count", 32'(count), 32'd0);

        tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
